// File: rtl/fp_round_pipe_pkg.sv
// fp_round_pipe_pkg -- shared FPU constants for single-precision rounding.
//   rm_e            : rounding-mode encoding (RNE, RZ, RU, RD)
//   EXP_MAX_FINITE  : largest finite biased exponent
//   EXP_INF         : exponent of infinity / NaN
//   inf_pattern()   : signed infinity
//   max_finite()    : signed largest finite value
//   overflow_to_inf : whether an overflowing result becomes infinity under rm
`timescale 1ns/1ps
package fp_round_pipe_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_RU  = 2'b10,
    RM_RD  = 2'b11
  } rm_e;

  localparam logic [7:0]  EXP_MAX_FINITE = 8'hFE;
  localparam logic [7:0]  EXP_INF        = 8'hFF;
  localparam logic [22:0] FRAC_ALL_ONES  = 23'h7F_FFFF;

  function automatic logic [31:0] inf_pattern(input logic sign);
    return {sign, EXP_INF, 23'd0};
  endfunction

  function automatic logic [31:0] max_finite(input logic sign);
    return {sign, EXP_MAX_FINITE, FRAC_ALL_ONES};
  endfunction

  // Round-to-nearest and the directed mode pointing away from zero saturate
  // to infinity; the inward-pointing modes saturate to max-finite.
  function automatic logic overflow_to_inf(input rm_e rm, input logic sign);
    return (rm == RM_RNE) || (rm == RM_RU && !sign) || (rm == RM_RD && sign);
  endfunction

endpackage

// File: rtl/fp_round_pipe_decide.sv
// fp_round_decide -- combinational rounding decision, reusable by any rounder.
//   rm      : rounding mode
//   sign    : sign of the value
//   frac    : lsb (bit 8), guard (bit 7) and sticky source bits (6:0)
//   incr    : add one ulp to the kept significand
//   inexact : discarded bits are non-zero
`timescale 1ns/1ps
module fp_round_decide
  import fp_round_pipe_pkg::*;
(
  input  rm_e        rm,
  input  logic       sign,
  input  logic [8:0] frac,
  output logic       incr,
  output logic       inexact
);

  logic lsb;
  logic guard;
  logic sticky;

  assign lsb     = frac[8];
  assign guard   = frac[7];
  assign sticky  = |frac[6:0];
  assign inexact = guard | sticky;

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    incr = 1'b0;
    case (rm)
      RM_RNE:  incr = guard & (sticky | lsb);
      RM_RZ:   incr = 1'b0;
      RM_RU:   incr = inexact & !sign;
      RM_RD:   incr = inexact & sign;
      default: incr = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_round_pipe.sv
// fp_round_pipe -- two-stage rounder from a normalized 32-bit significand to
// IEEE-754 single precision, with valid/ready handshakes on both sides.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid / in_ready       : operand handshake
//   in_sign, in_exp, in_frac  : operand (in_frac[31] hidden one, [7:0] round bits)
//   in_zero                   : operand is exactly zero
//   rm                        : rounding mode, captured with the operand
//   out_valid / out_ready     : result handshake
//   out_a                     : packed single-precision result
//   out_inexact, out_overflow : exception flags
// S1 holds the decoded operand and the round decision; S2 holds the packed
// result and drives the outputs directly, so they stay stable while stalled.
`timescale 1ns/1ps
module fp_round_pipe
  import fp_round_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [31:0] in_frac,
  input  logic        in_zero,
  input  logic [1:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic        out_inexact,
  output logic        out_overflow
);

  // ---------------- S1: decode / round decision ----------------
  logic        s1_valid;
  logic        s1_sign;
  logic        s1_zero;
  rm_e         s1_rm;
  logic [7:0]  s1_exp;
  logic [22:0] s1_frac;
  logic        s1_incr;
  logic        s1_inexact;
  logic        s1_guard;

  logic        dec_incr;
  logic        dec_inexact;
  logic        s2_advance;

  // The hidden one is implied by normalization and rebuilt in S2.
  logic        unused_hidden;
  assign unused_hidden = in_frac[31];

  assign s2_advance = !out_valid | out_ready;
  assign in_ready   = !rst & (!s1_valid | s2_advance);

  fp_round_decide u_decide (
    .rm      (rm_e'(rm)),
    .sign    (in_sign),
    .frac    (in_frac[8:0]),
    .incr    (dec_incr),
    .inexact (dec_inexact)
  );

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block order.
    if (rst)           s1_valid <= 1'b0;
    else if (in_ready) s1_valid <= in_valid;
  end

  // NOTE: payload registers carry no reset; s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_sign    <= in_sign;
      s1_zero    <= in_zero;
      s1_rm      <= rm_e'(rm);
      s1_exp     <= in_exp;
      s1_frac    <= in_frac[30:8];
      s1_incr    <= dec_incr;
      s1_inexact <= dec_inexact;
      s1_guard   <= in_frac[7];
    end
  end

  // ---------------- S2: increment / renormalize / pack ----------------
  logic [24:0] sum;
  logic        carry;
  logic [7:0]  exp_r;
  logic [22:0] frac_r;
  logic        ovf;
  logic [31:0] nxt_a;
  logic        nxt_inexact;
  logic        nxt_overflow;

  always_comb begin
    sum    = {2'b01, s1_frac} + {24'd0, s1_incr};
    carry  = sum[24];
    exp_r  = s1_exp + {7'd0, carry};
    frac_r = carry ? 23'd0 : sum[22:0];
    // Overflow is judged on magnitude: either this mode's own increment
    // carries the exponent to 0xFF, or the operand sits at or above the
    // midpoint past max-finite (where round-to-nearest would carry). The
    // inward-pointing modes then saturate instead of reaching infinity.
    ovf = (exp_r == EXP_INF) ||
          (s1_exp == EXP_MAX_FINITE && s1_frac == FRAC_ALL_ONES && s1_guard);

    nxt_a        = {s1_sign, exp_r, frac_r};
    nxt_inexact  = s1_inexact;
    nxt_overflow = 1'b0;
    if (s1_zero) begin
      nxt_a       = {s1_sign, 31'd0};
      nxt_inexact = 1'b0;
    end else if (ovf) begin
      nxt_a        = overflow_to_inf(s1_rm, s1_sign) ? inf_pattern(s1_sign)
                                                     : max_finite(s1_sign);
      nxt_inexact  = 1'b1;
      nxt_overflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_a        <= 32'd0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_a        <= nxt_a;
        out_inexact  <= nxt_inexact;
        out_overflow <= nxt_overflow;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe -- scoreboard bench for fp_round_pipe. The driver pushes
// the hand-computed result of each accepted operand; the monitor compares
// every presented output against the queue head and pops on transfer.
`timescale 1ns/1ps
module tb_fp_round_pipe;
  import fp_round_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [31:0] in_frac;
  logic        in_zero;
  logic [1:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic        out_inexact;
  logic        out_overflow;

  always #5 clk = ~clk;

  fp_round_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_frac      (in_frac),
    .in_zero      (in_zero),
    .rm           (rm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_inexact  (out_inexact),
    .out_overflow (out_overflow)
  );

  typedef struct packed {
    logic [31:0] a;
    logic        inexact;
    logic        overflow;
  } res_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [31:0] frac;
    logic        zero;
    logic [1:0]  rm;
    res_t        res;
  } vec_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_recv   = 0;
  bit   saw_in_ready_low;

  task automatic check(input string name, input logic [33:0] act,
                       input logic [33:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [7:0] e,
                              input logic [31:0] f, input logic z,
                              input logic [1:0] m, input logic [31:0] a,
                              input logic ix, input logic ov);
    vec_t v;
    v.sign = s; v.exp = e; v.frac = f; v.zero = z; v.rm = m;
    v.res  = '{a: a, inexact: ix, overflow: ov};
    return v;
  endfunction

  // Drive at the falling edge; the operand transfers at the first rising
  // edge where in_ready was high, at which point its result is queued.
  task automatic send(input vec_t v);
    bit acc;
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_frac  = v.frac;
    in_zero  = v.zero;
    rm       = v.rm;
    for (int t = 0; t < 50; t++) begin
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) begin
        sb_q.push_back(v.res);
        #1 in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected 1");
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    check(name, 34'(sb_q.size()), 34'd0);
  endtask

  // Monitor: any presented output must match the oldest outstanding result.
  initial begin
    res_t tmp;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h, expected no output", out_a);
        end else begin
          check($sformatf("result_%0d", n_recv),
                {out_a, out_inexact, out_overflow}, sb_q[0]);
          if (out_ready) begin
            tmp = sb_q.pop_front();
            n_recv++;
          end
        end
      end
    end
  end

  vec_t vecs[14];
  int   recv_base;

  initial begin
    vecs[0]  = mk(0, 8'h9D, 32'hFFFF_FFFE, 0, 2'b00, 32'h4F00_0000, 1, 0);
    vecs[1]  = mk(0, 8'h9D, 32'hFFFF_FFFE, 0, 2'b01, 32'h4EFF_FFFF, 1, 0);
    vecs[2]  = mk(0, 8'h97, 32'h8000_0080, 0, 2'b00, 32'h4B80_0000, 1, 0);
    vecs[3]  = mk(0, 8'h97, 32'h8000_0080, 0, 2'b10, 32'h4B80_0001, 1, 0);
    vecs[4]  = mk(0, 8'h97, 32'h8000_0080, 0, 2'b11, 32'h4B80_0000, 1, 0);
    vecs[5]  = mk(1, 8'h97, 32'h8000_0080, 0, 2'b11, 32'hCB80_0001, 1, 0);
    vecs[6]  = mk(0, 8'hFE, 32'hFFFF_FFFF, 0, 2'b00, 32'h7F80_0000, 1, 1);
    vecs[7]  = mk(0, 8'hFE, 32'hFFFF_FFFF, 0, 2'b01, 32'h7F7F_FFFF, 1, 1);
    vecs[8]  = mk(1, 8'hFE, 32'hFFFF_FFFF, 0, 2'b10, 32'hFF7F_FFFF, 1, 1);
    vecs[9]  = mk(1, 8'hFE, 32'hFFFF_FFFF, 0, 2'b11, 32'hFF80_0000, 1, 1);
    vecs[10] = mk(0, 8'h55, 32'h1234_5678, 1, 2'b10, 32'h0000_0000, 0, 0);
    vecs[11] = mk(1, 8'h55, 32'hFFFF_FFFF, 1, 2'b00, 32'h8000_0000, 0, 0);
    vecs[12] = mk(0, 8'h9E, 32'h8000_0000, 0, 2'b00, 32'h4F00_0000, 0, 0);
    vecs[13] = mk(0, 8'hFE, 32'hFFFF_FF7F, 0, 2'b00, 32'h7F7F_FFFF, 1, 0);

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'h0;
    in_frac = 32'h0; in_zero = 1'b0; rm = 2'b00; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 34'(out_valid), 34'd0);
    check("rst_in_ready", 34'(in_ready), 34'd0);
    check("rst_outputs", {out_a, out_inexact, out_overflow}, 34'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("in_ready_after_rst", 34'(in_ready), 34'd1);

    // Two-cycle latency with an exact operand
    send(vecs[12]);
    check("lat_edge1_valid", 34'(out_valid), 34'd0);
    @(posedge clk);
    #1 check("lat_edge2_valid", 34'(out_valid), 34'd1);

    // Directed rounding vectors, back to back
    for (int i = 0; i < 14; i++) send(vecs[i]);
    wait_drain("drain_directed");

    // Five-operand stream with out_ready low in cycles 3-6
    recv_base = n_recv;
    saw_in_ready_low = 1'b0;
    fork
      begin
        send(vecs[2]); send(vecs[3]); send(vecs[5]); send(vecs[6]); send(vecs[12]);
      end
      begin
        for (int c = 1; c <= 12; c++) begin
          @(negedge clk);
          out_ready = !(c >= 3 && c <= 6);
          #1 if (!in_ready) saw_in_ready_low = 1'b1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("drain_stream");
    check("stream_in_ready_fell", 34'(saw_in_ready_low), 34'd1);
    check("stream_count", 34'(n_recv - recv_base), 34'd5);

    // Reset with both stages full
    out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[1]);
    #1 check("full_in_ready", 34'(in_ready), 34'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_pulse_in_ready", 34'(in_ready), 34'd0);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    out_ready = 1'b1;
    #1;
    check("post_rst_out_valid", 34'(out_valid), 34'd0);
    check("post_rst_in_ready", 34'(in_ready), 34'd1);
    recv_base = n_recv;
    send(vecs[3]);
    check("post_rst_lat1", 34'(out_valid), 34'd0);
    @(posedge clk);
    #1 check("post_rst_lat2", 34'(out_valid), 34'd1);
    wait_drain("drain_post_rst");
    check("post_rst_count", 34'(n_recv - recv_base), 34'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_round_pipe.md
FP_ROUND_PIPE -- requirements
Module: fp_round_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  upstream normalizer offers an operand.
REQ-005 in_ready  output  1  block accepts the operand this cycle.
REQ-006 in_sign  input  1  sign of the value.
REQ-007 in_exp  input  8  biased exponent, range 0x01..0xFE.
REQ-008 in_frac  input  32  normalized significand: bit31 is the hidden 1, bits 30:8 are the fraction, bits 7:0 are round bits.
REQ-009 in_zero  input  1  the value is exactly zero; in_exp and in_frac are ignored.
REQ-010 rm  input  2  rounding mode, sampled with the operand: 00 RNE, 01 RZ, 10 RU (+inf), 11 RD (-inf).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_a  output  32  IEEE-754 single-precision result.
REQ-014 out_inexact  output  1  result differs from the exact value.
REQ-015 out_overflow  output  1  exponent rounded past 0xFE.

Function
REQ-016 Transfers SHALL be valid/ready: a transfer occurs when valid and ready are both high on the same edge.
REQ-017 The pipeline SHALL have two register stages: S1 (decode/round decision) and S2 (increment/renormalize/pack). Latency is 2 cycles from input transfer to out_valid when there is no stall.
REQ-018 in_ready = !s1_valid | s2_advance, where s2_advance = !s2_valid | out_ready. The stages collapse bubbles, and full throughput is one result per cycle.
REQ-019 Once out_valid is asserted, out_a and the flags SHALL hold stable until the transfer completes.
REQ-020 Stage S1 SHALL use the following bits:
  - lsb = in_frac[8]
  - guard = in_frac[7]
  - sticky = |in_frac[6:0]
  - inexact = guard | sticky
REQ-021 The increment SHALL be:
  - RNE: guard & (sticky | lsb)
  - RZ: 0
  - RU: inexact & !sign
  - RD: inexact & sign
REQ-022 Stage S2 SHALL compute a 24-bit sum = {1, in_frac[30:8]} + increment. On carry out, the fraction becomes 0 and the exponent is incremented by 1.
REQ-023 If the post-round exponent equals 0xFF, then out_overflow = 1 and out_inexact = 1. The result SHALL be:
  - infinity {sign, 0xFF, 0} for RNE, for RU with sign 0, and for RD with sign 1
  - otherwise max-finite {sign, 0xFE, 0x7FFFFF}
REQ-024 If in_zero is set, then out_a = {in_sign, 31'b0} and both flags are 0.
REQ-025 Simultaneous input and output transfers in the same cycle SHALL both complete, with no loss or duplication.

Reset
REQ-026 While rst is high at an edge, s1_valid, s2_valid, and out_valid SHALL go to 0. out_a, out_inexact, and out_overflow SHALL go to 0.
REQ-027 While rst is high, in_ready SHALL be 0. In-flight operands are discarded without output.
REQ-028 in_ready SHALL be 1 on the first cycle after rst is released.

Structure
REQ-029 The rounding-mode encodings, the exponent constants (0xFE, 0xFF), and the max-finite/infinity patterns SHALL reside in the shared FPU package.
REQ-030 The S1 increment decision SHALL be a sub-module named fp_round_decide (combinational: rm, sign, frac[8:0] -> incr, inexact), so the future adder and multiplier rounders can reuse it.

Verification
REQ-031 exp=0x9D, frac=0xFFFFFFFE, RNE -> out_a=0x4F000000, inexact=1, overflow=0. The same operand with RZ -> 0x4EFFFFFF, inexact=1.
REQ-032 Tie case: exp=0x97, frac=0x80000080, sign=0:
  - RNE -> 0x4B800000, inexact=1
  - RU -> 0x4B800001
  - RD -> 0x4B800000
REQ-033 exp=0xFE, frac=0xFFFFFFFF, sign=0:
  - RNE -> 0x7F800000, overflow=1, inexact=1
  - RZ -> 0x7F7FFFFF, overflow=1
REQ-034 in_zero=1, sign=0, any rm -> 0x00000000, flags 0. An exact operand exp=0x9E, frac=0x80000000 -> 0x4F000000, inexact=0.
REQ-035 Back-to-back stream of 5 operands with out_ready held low for cycles 3-6:
  - in_ready falls when both stages are full
  - results emerge in order, none dropped or duplicated
  - out_a is stable while stalled
REQ-036 rst asserted for 1 cycle with both stages valid -> out_valid=0 next cycle, no stale result emerges, and a new operand completes with 2-cycle latency.
